// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decode/regfile outputs, detects load-use hazards,
// and handles flush/stall. Optional perf counters built when ID_EX_PERF_CNT_EN is defined.
module id_ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [4:0]      rs1_label_i,
    input  logic [4:0]      rs2_label_i,
    input  logic [4:0]      rd_label_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [3:0]      alu_op_i,
    input  logic            alu_src_i,
    input  logic [2:0]      funct3_i,
    input  logic            mem_read_i,
    input  logic            mem_write_i,
    input  logic            reg_write_en_i,
    input  logic            flush_i,
    input  logic            ex_stall_i,
    output logic            stall_o,
    output logic            valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] imm_o,
    output logic [4:0]      rs1_label_o,
    output logic [4:0]      rs2_label_o,
    output logic [4:0]      rd_label_o,
    output logic [XLEN-1:0] rs1_data_o,
    output logic [XLEN-1:0] rs2_data_o,
    output logic [3:0]      alu_op_o,
    output logic            alu_src_o,
    output logic [2:0]      funct3_o,
    output logic            mem_read_o,
    output logic            mem_write_o,
    output logic            reg_write_en_o,
    output logic [31:0]     stall_cnt_o,
    output logic [31:0]     flush_cnt_o
);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [3:0]      alu_op;
        logic            alu_src;
        logic [2:0]      funct3;
        logic            mem_read;
        logic            mem_write;
        logic            reg_we;
    } id_ex_t;

    id_ex_t q, cap;
    logic   load_use;

    // Side effects of an invalid decode slot must never reach EX.
    always_comb begin
        cap.valid     = valid_i;
        cap.pc        = pc_i;
        cap.imm       = imm_i;
        cap.rs1       = rs1_label_i;
        cap.rs2       = rs2_label_i;
        cap.rd        = rd_label_i;
        cap.rs1_data  = rs1_data_i;
        cap.rs2_data  = rs2_data_i;
        cap.alu_op    = alu_op_i;
        cap.alu_src   = alu_src_i;
        cap.funct3    = funct3_i;
        cap.mem_read  = mem_read_i & valid_i;
        cap.mem_write = mem_write_i & valid_i;
        cap.reg_we    = reg_write_en_i & valid_i;
    end

    assign load_use = q.valid & q.mem_read & (q.rd != 5'd0) & valid_i &
                      ((rs1_label_i == q.rd) | (rs2_label_i == q.rd));
    assign stall_o  = (load_use | ex_stall_i) & ~flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)          q <= '0;
        else if (flush_i)     q <= '0;
        else if (ex_stall_i)  q <= q;
        else if (load_use)    q <= '0;
        else                  q <= cap;
    end

    assign valid_o        = q.valid;
    assign pc_o           = q.pc;
    assign imm_o          = q.imm;
    assign rs1_label_o    = q.rs1;
    assign rs2_label_o    = q.rs2;
    assign rd_label_o     = q.rd;
    assign rs1_data_o     = q.rs1_data;
    assign rs2_data_o     = q.rs2_data;
    assign alu_op_o       = q.alu_op;
    assign alu_src_o      = q.alu_src;
    assign funct3_o       = q.funct3;
    assign mem_read_o     = q.mem_read;
    assign mem_write_o    = q.mem_write;
    assign reg_write_en_o = q.reg_we;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    // Counters saturate rather than wrap so long runs stay monotonic.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!flush_i && !ex_stall_i && load_use && stall_cnt_q != 32'hFFFF_FFFF)
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush_i && q.valid && flush_cnt_q != 32'hFFFF_FFFF)
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    assign stall_cnt_o = 32'h0;
    assign flush_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table, hand sequences, random vs model.
module tb_id_ex_stage;

`ifdef ID_EX_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [3:0]  alu_op;
        logic        alu_src;
        logic [2:0]  f3;
        logic        mr;
        logic        mw;
        logic        we;
    } st_t;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1;
        logic        mr, we, flush, xs;
        logic        e_stall, e_valid;
        logic [31:0] e_pc;
        logic [4:0]  e_rd;
        logic        e_mr, e_we;
        logic [31:0] e_d1;
    } vec_t;

    logic clk_i = 1'b0;
    logic rst_ni;
    st_t  din;
    logic flush_i, ex_stall_i;
    logic        stall_o, valid_o, alu_src_o, mem_read_o, mem_write_o, reg_write_en_o;
    logic [31:0] pc_o, imm_o, rs1_data_o, rs2_data_o, stall_cnt_o, flush_cnt_o;
    logic [4:0]  rs1_label_o, rs2_label_o, rd_label_o;
    logic [3:0]  alu_op_o;
    logic [2:0]  funct3_o;

    int total = 0;
    int bad = 0;
    st_t m;
    logic [31:0] m_sc, m_fc;

    always #5 clk_i = ~clk_i;

    id_ex_stage #(.XLEN(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(din.valid), .pc_i(din.pc), .imm_i(din.imm),
        .rs1_label_i(din.rs1), .rs2_label_i(din.rs2), .rd_label_i(din.rd),
        .rs1_data_i(din.d1), .rs2_data_i(din.d2), .alu_op_i(din.alu_op), .alu_src_i(din.alu_src),
        .funct3_i(din.f3), .mem_read_i(din.mr), .mem_write_i(din.mw), .reg_write_en_i(din.we),
        .flush_i(flush_i), .ex_stall_i(ex_stall_i), .stall_o(stall_o),
        .valid_o(valid_o), .pc_o(pc_o), .imm_o(imm_o), .rs1_label_o(rs1_label_o),
        .rs2_label_o(rs2_label_o), .rd_label_o(rd_label_o), .rs1_data_o(rs1_data_o),
        .rs2_data_o(rs2_data_o), .alu_op_o(alu_op_o), .alu_src_o(alu_src_o), .funct3_o(funct3_o),
        .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .reg_write_en_o(reg_write_en_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " valid_o"}, 32'(valid_o), 32'(m.valid));
        chk({tag, " pc_o"}, pc_o, m.pc);
        chk({tag, " imm_o"}, imm_o, m.imm);
        chk({tag, " rs1_label_o"}, 32'(rs1_label_o), 32'(m.rs1));
        chk({tag, " rs2_label_o"}, 32'(rs2_label_o), 32'(m.rs2));
        chk({tag, " rd_label_o"}, 32'(rd_label_o), 32'(m.rd));
        chk({tag, " rs1_data_o"}, rs1_data_o, m.d1);
        chk({tag, " rs2_data_o"}, rs2_data_o, m.d2);
        chk({tag, " alu_op_o"}, 32'(alu_op_o), 32'(m.alu_op));
        chk({tag, " alu_src_o"}, 32'(alu_src_o), 32'(m.alu_src));
        chk({tag, " funct3_o"}, 32'(funct3_o), 32'(m.f3));
        chk({tag, " mem_read_o"}, 32'(mem_read_o), 32'(m.mr));
        chk({tag, " mem_write_o"}, 32'(mem_write_o), 32'(m.mw));
        chk({tag, " reg_write_en_o"}, 32'(reg_write_en_o), 32'(m.we));
        chk({tag, " stall_cnt_o"}, stall_cnt_o, m_sc);
        chk({tag, " flush_cnt_o"}, flush_cnt_o, m_fc);
    endtask

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Hazard rule: the instruction in EX is a real load to a nonzero register that decode reads.
    function automatic logic hazard(input st_t ex, input st_t dec);
        return ex.valid && ex.mr && ex.rd != 5'd0 && dec.valid &&
               (dec.rs1 == ex.rd || dec.rs2 == ex.rd);
    endfunction

    // Caller sets inputs just after an edge; this checks stall_o, clocks once, checks outputs.
    task automatic step(input string tag);
        logic lu;
        #1;
        lu = hazard(m, din);
        chk({tag, " stall_o"}, 32'(stall_o), 32'((lu || ex_stall_i) && !flush_i));
        @(posedge clk_i);
        if (flush_i) begin
            if (PERF && m.valid) m_fc = sat_inc(m_fc);
            m = '0;
        end else if (ex_stall_i) begin
            m = m;
        end else if (lu) begin
            if (PERF) m_sc = sat_inc(m_sc);
            m = '0;
        end else begin
            m = din;
            if (!din.valid) begin
                m.mr = 1'b0; m.mw = 1'b0; m.we = 1'b0;
            end
        end
        #1;
        check_all(tag);
    endtask

    function automatic vec_t mk(input logic v, input logic [31:0] pc, input logic [4:0] r1, r2, rd,
                                input logic [31:0] d1, input logic mr, we, fl, xs,
                                input logic es, ev, input logic [31:0] epc, input logic [4:0] erd,
                                input logic emr, ewe, input logic [31:0] ed1);
        vec_t t;
        t.valid = v; t.pc = pc; t.rs1 = r1; t.rs2 = r2; t.rd = rd; t.d1 = d1;
        t.mr = mr; t.we = we; t.flush = fl; t.xs = xs;
        t.e_stall = es; t.e_valid = ev; t.e_pc = epc; t.e_rd = erd;
        t.e_mr = emr; t.e_we = ewe; t.e_d1 = ed1;
        return t;
    endfunction

    task automatic set_plain(input logic v, input logic [31:0] pc, input logic [4:0] r1, r2, rd,
                             input logic [31:0] d1, input logic mr, we);
        din = '0;
        din.valid = v; din.pc = pc; din.rs1 = r1; din.rs2 = r2; din.rd = rd;
        din.d1 = d1; din.mr = mr; din.we = we;
    endtask

    vec_t tbl[8];

    initial begin
        //            v  pc       r1 r2 rd d1            mr we fl xs | st ev e_pc     erd emr ewe e_d1
        tbl[0] = mk(1, 32'h100, 1, 2, 3, 32'hDEADBEEF, 0, 1, 0, 0,  0, 1, 32'h100, 3, 0, 1, 32'hDEADBEEF);
        tbl[1] = mk(1, 32'h104, 1, 2, 5, 32'h11,       1, 1, 0, 0,  0, 1, 32'h104, 5, 1, 1, 32'h11);
        tbl[2] = mk(1, 32'h108, 6, 5, 7, 32'h22,       0, 1, 0, 0,  1, 0, 32'h0,   0, 0, 0, 32'h0);
        tbl[3] = mk(1, 32'h108, 6, 5, 7, 32'h22,       0, 1, 0, 0,  0, 1, 32'h108, 7, 0, 1, 32'h22);
        tbl[4] = mk(1, 32'h10C, 7, 0, 0, 32'h33,       1, 1, 0, 0,  0, 1, 32'h10C, 0, 1, 1, 32'h33);
        tbl[5] = mk(1, 32'h110, 0, 0, 8, 32'h44,       0, 1, 0, 0,  0, 1, 32'h110, 8, 0, 1, 32'h44);
        tbl[6] = mk(0, 32'h114, 1, 1, 9, 32'h55,       1, 1, 0, 0,  0, 0, 32'h114, 9, 0, 0, 32'h55);
        tbl[7] = mk(1, 32'h118, 1, 1, 10, 32'h66,      0, 1, 1, 1,  0, 0, 32'h0,   0, 0, 0, 32'h0);

        m = '0; m_sc = '0; m_fc = '0;
        din = '0; flush_i = 0; ex_stall_i = 0;
        rst_ni = 1'b0;
        #12;
        check_all("reset");
        chk("reset stall_o", 32'(stall_o), 32'd0);
        rst_ni = 1'b1;

        // Directed table from the reset state; first entry is also the first edge after release.
        for (int i = 0; i < 8; i++) begin
            set_plain(tbl[i].valid, tbl[i].pc, tbl[i].rs1, tbl[i].rs2, tbl[i].rd,
                      tbl[i].d1, tbl[i].mr, tbl[i].we);
            flush_i = tbl[i].flush; ex_stall_i = tbl[i].xs;
            #1;
            chk($sformatf("tbl%0d stall", i), 32'(stall_o), 32'(tbl[i].e_stall));
            step($sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d e_valid", i), 32'(valid_o), 32'(tbl[i].e_valid));
            chk($sformatf("tbl%0d e_pc", i), pc_o, tbl[i].e_pc);
            chk($sformatf("tbl%0d e_rd", i), 32'(rd_label_o), 32'(tbl[i].e_rd));
            chk($sformatf("tbl%0d e_mr", i), 32'(mem_read_o), 32'(tbl[i].e_mr));
            chk($sformatf("tbl%0d e_we", i), 32'(reg_write_en_o), 32'(tbl[i].e_we));
            chk($sformatf("tbl%0d e_d1", i), rs1_data_o, tbl[i].e_d1);
        end
        chk("stall_cnt after table", stall_cnt_o, PERF ? 32'd1 : 32'd0);
        flush_i = 0; ex_stall_i = 0;

        // Flush beats both ex_stall and a live load-use hazard.
        set_plain(1, 32'h180, 1, 2, 5, 32'h77, 1, 1);
        step("fl_load");
        set_plain(1, 32'h184, 5, 5, 6, 32'h88, 0, 1);
        flush_i = 1; ex_stall_i = 1;
        #1;
        chk("fl stall_o", 32'(stall_o), 32'd0);
        step("fl_kill");
        chk("fl valid_o", 32'(valid_o), 32'd0);
        chk("fl flush_cnt", flush_cnt_o, PERF ? 32'd1 : 32'd0);
        flush_i = 0; ex_stall_i = 0;

        // Downstream stall for three cycles freezes pc_o.
        set_plain(1, 32'h200, 1, 2, 3, 32'h99, 0, 1);
        step("ds_cap");
        for (int k = 0; k < 3; k++) begin
            set_plain(1, 32'h300 + 32'(k), 1, 2, 4, 32'hAA, 0, 1);
            ex_stall_i = 1;
            #1;
            chk($sformatf("ds%0d stall_o", k), 32'(stall_o), 32'd1);
            step($sformatf("ds%0d", k));
            chk($sformatf("ds%0d pc_o", k), pc_o, 32'h200);
        end
        ex_stall_i = 0;
        set_plain(1, 32'h204, 1, 2, 3, 32'hBB, 0, 1);
        step("ds_rel");
        chk("ds_rel pc_o", pc_o, 32'h204);

        // Asynchronous reset mid-cycle while a valid instruction sits in EX.
        set_plain(1, 32'h208, 1, 2, 5, 32'hCC, 1, 1);
        step("rst_pre");
        set_plain(1, 32'h20C, 5, 5, 6, 32'hDD, 0, 1);
        #3;
        rst_ni = 1'b0;
        #1;
        m = '0; m_sc = '0; m_fc = '0;
        check_all("midrst");
        chk("midrst stall_o", 32'(stall_o), 32'd0);
        #1;
        rst_ni = 1'b1;
        step("post_rst");
        chk("post_rst valid_o", 32'(valid_o), 32'd1);

        // Random traffic against the model; small label range provokes hazards.
        for (int n = 0; n < 400; n++) begin
            din.valid   = ($urandom % 4) != 0;
            din.pc      = $urandom;
            din.imm     = $urandom;
            din.rs1     = 5'($urandom_range(0, 3));
            din.rs2     = 5'($urandom_range(0, 3));
            din.rd      = 5'($urandom_range(0, 3));
            din.d1      = $urandom;
            din.d2      = $urandom;
            din.alu_op  = 4'($urandom);
            din.alu_src = 1'($urandom);
            din.f3      = 3'($urandom);
            din.mr      = ($urandom % 3) == 0;
            din.mw      = ($urandom % 4) == 0;
            din.we      = 1'($urandom);
            flush_i     = ($urandom % 8) == 0;
            ex_stall_i  = ($urandom % 6) == 0;
            step("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
